// File: rtl/mid_unit_inverse_pkg.sv
// Shared types for the mid_unit inverse pipeline: occupancy encoding of the
// two per-stage valid bits.
package mid_unit_inverse_pkg;

  // occupancy | meaning
  // EMPTY     | no stage holds data
  // TAIL      | only stage 2 holds data
  // HEAD      | only stage 1 holds data
  // FULL      | both stages hold data
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_TAIL  = 2'b01,
    OCC_HEAD  = 2'b10,
    OCC_FULL  = 2'b11
  } occ_t;

  function automatic occ_t occupancy(input logic v1, input logic v2);
    return occ_t'({v1, v2});
  endfunction

endpackage

// File: rtl/mid_unit_inverse_sub_stage.sv
// One elastic registered subtract stage: d = a - b (mod 2^W), with the
// subtrahend forwarded so the next stage can subtract it again.
module sub_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] pass,
  output logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Data only loads with a valid beat, so idle X operands never enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pass      <= '0;
      d         <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        pass <= b;
        d    <= a - b;
      end
    end
  end

endmodule

// File: rtl/mid_unit_inverse.sv
// Recovers y = (z - 2*x) mod 2^W from mid_unit (x, z) pairs using two
// chained subtract stages, and counts completed output transfers.
module mid_unit_inverse
  import mid_unit_inverse_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y,
  output logic          busy,
  output logic [CW-1:0] out_count
);

  logic         v1;
  logic         ready2;
  logic [W-1:0] x1;
  logic [W-1:0] t1;
  logic [W-1:0] unused_x2;
  occ_t         occ;

  sub_stage #(.W(W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (in_z),
    .b         (in_x),
    .pass      (x1),
    .d         (t1),
    .out_valid (v1),
    .out_ready (ready2)
  );

  sub_stage #(.W(W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .in_ready  (ready2),
    .a         (t1),
    .b         (x1),
    .pass      (unused_x2),
    .d         (out_y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign occ  = occupancy(v1, out_valid);
  assign busy = (occ != OCC_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mid_unit_inverse.sv
// Scoreboard bench for mid_unit_inverse: expected y values are queued on
// input transfers and popped by a monitor on output transfers.
module tb_mid_unit_inverse;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready_c;
  logic [7:0]  in_x, in_z;
  logic        out_valid, out_valid_c;
  logic        out_ready;
  logic [7:0]  out_y, out_y_c;
  logic        busy, busy_c;
  logic [15:0] out_count;
  logic [3:0]  out_count_c;

  logic [7:0]  stim_y;
  logic [7:0]  exp_q[$];
  int          model_count = 0;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  bit          rand_on = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  mid_unit_inverse #(.W(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .busy(busy), .out_count(out_count)
  );

  mid_unit_inverse #(.W(8), .CW(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_x(in_x), .in_z(in_z), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_y(out_y_c), .busy(busy_c), .out_count(out_count_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(stim_y);
      if (out_valid && out_ready) begin
        chk("out_count_before", {16'h0, out_count}, model_count % 65536);
        chk("out_count_c_before", {28'h0, out_count_c}, model_count % 16);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", out_y);
        end else begin
          chk("out_y", {24'h0, out_y}, {24'h0, exp_q.pop_front()});
        end
        model_count++;
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] z, input logic [7:0] y,
                      output int waits);
    int k;
    in_valid = 1'b1;
    in_x = x;
    in_z = z;
    stim_y = y;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    if (k == 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
    waits = k;
  endtask

  task automatic send_rand(output int waits);
    logic [7:0] x, y;
    x = 8'($urandom);
    y = 8'($urandom);
    send(x, 8'(2 * x + y), y, waits);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_x = 8'($urandom);
    in_z = 8'($urandom);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 300; k++) begin
      if (!busy && exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy=%0d pending=%0d expected 0", busy, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int w;
    int c0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = 8'h0;
    in_z = 8'h0;
    stim_y = 8'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_out_valid", {31'h0, out_valid}, 0);
    chk("reset_busy", {31'h0, busy}, 0);
    chk("reset_out_count", {16'h0, out_count}, 0);
    chk("reset_out_y", {24'h0, out_y}, 0);
    chk("reset_in_ready", {31'h0, in_ready}, 1);

    // Single transfer and its latency
    send(8'd3, 8'd11, 8'd5, w);
    chk("first_accept_wait", w, 0);
    idle();
    chk("lat_stage1_only", {31'h0, out_valid}, 0);
    chk("lat_busy", {31'h0, busy}, 1);
    @(posedge clk);
    #1;
    chk("lat_out_valid", {31'h0, out_valid}, 1);
    chk("lat_out_y", {24'h0, out_y}, 5);
    @(posedge clk);
    #1;
    chk("first_out_count", {16'h0, out_count}, 1);
    chk("first_idle", {31'h0, out_valid}, 0);

    // Wrap cases
    send(8'h80, 8'h10, 8'h10, w);
    send(8'hFF, 8'hFD, 8'hFF, w);
    send(8'h00, 8'h00, 8'h00, w);
    idle();
    wait_drain();

    // Back-to-back random stream
    do_reset();
    c0 = cycle;
    for (int i = 0; i < 100; i++) send_rand(w);
    chk("stream_cycles", cycle - c0, 100);
    idle();
    wait_drain();
    chk("stream_out_count", {16'h0, out_count}, 100);

    // Backpressure stall
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 8'h11; in_z = 8'h33; stim_y = 8'h11;
    @(posedge clk);
    #1;
    in_x = 8'h40; in_z = 8'h85; stim_y = 8'h05;
    @(posedge clk);
    #1;
    in_x = 8'h01; in_z = 8'h07; stim_y = 8'h05;
    chk("stall_in_ready", {31'h0, in_ready}, 0);
    chk("stall_busy", {31'h0, busy}, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold_valid", {31'h0, out_valid}, 1);
    chk("stall_hold_y", {24'h0, out_y}, 8'h11);
    chk("stall_hold_ready", {31'h0, in_ready}, 0);
    out_ready = 1'b1;
    send(8'h01, 8'h07, 8'h05, w);
    chk("release_no_bubble", w, 0);

    // Random backpressure
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      send_rand(w);
    end
    idle();
    rand_on = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    chk("full_before_reset", {31'h0, in_ready}, 0);
    do_reset();
    chk("mid_reset_out_valid", {31'h0, out_valid}, 0);
    chk("mid_reset_busy", {31'h0, busy}, 0);
    chk("mid_reset_out_count", {16'h0, out_count}, 0);
    chk("mid_reset_in_ready", {31'h0, in_ready}, 1);
    out_ready = 1'b1;

    // Counter wrap on the CW=4 instance
    for (int i = 0; i < 17; i++) send_rand(w);
    idle();
    wait_drain();
    @(posedge clk);
    #1;
    chk("wrap_out_count_c", {28'h0, out_count_c}, 1);
    chk("wrap_out_count", {16'h0, out_count}, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
